// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states and datapath select codes.
package mc_ctrl_pkg;

  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_ADDI  = 3'd1;
  localparam logic [2:0] OP_LW    = 3'd2;
  localparam logic [2:0] OP_SW    = 3'd3;
  localparam logic [2:0] OP_BEQ   = 3'd4;
  localparam logic [2:0] OP_BNE   = 3'd5;
  localparam logic [2:0] OP_J     = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_WB_MEM   = 4'd6;
  localparam logic [3:0] S_EXEC_R   = 4'd7;
  localparam logic [3:0] S_EXEC_I   = 4'd8;
  localparam logic [3:0] S_WB_ALU   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_HALT     = 4'd12;
  localparam logic [3:0] S_ERR      = 4'd15;

  localparam logic [1:0] ASB_REGB   = 2'b00;
  localparam logic [1:0] ASB_FOUR   = 2'b01;
  localparam logic [1:0] ASB_IMM    = 2'b10;
  localparam logic [1:0] ASB_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // States that own an outstanding memory request.
  function automatic logic is_mem_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  // States in which a stall request freezes the FSM.
  function automatic logic is_stallable(input logic [3:0] s);
    return (s == S_DECODE) || (s == S_MEM_ADDR) || (s == S_EXEC_R) || (s == S_EXEC_I) ||
           (s == S_WB_ALU) || (s == S_WB_MEM) || (s == S_BRANCH) || (s == S_JUMP);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive memory wait cycles and flags a timeout on the last permitted one.
module mc_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_i,
  output logic timeout_o
);
  import mc_ctrl_pkg::*;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_o = (TIMEOUT != 0) && wait_i && (cnt_q == CW'(TIMEOUT));

  // Any cycle that is not a stalled wait (ready, timeout, other state) restarts the count.
  always_comb begin
    cnt_d = '0;
    if ((TIMEOUT != 0) && wait_i && !timeout_o)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mc_controller_hs.sv
// Multicycle CPU control FSM with memory handshake/timeout, stall, branch evaluation, halt and trap.
module mc_controller_hs #(
  parameter int OPC_W         = 4,
  parameter int MEM_HANDSHAKE = 1,
  parameter int TIMEOUT       = 15,
  parameter int ILLEGAL_TRAP  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             stall,
  input  logic             resume,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             wb_sel,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state_o,
  output logic             busy,
  output logic             error
);
  import mc_ctrl_pkg::*;

  logic [3:0] state_q, state_d;
  logic       rdy, tmo, hold;
  logic       op_legal;
  logic [2:0] op3;

  assign rdy      = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign op3      = opcode[2:0];
  // All eight low codes are defined; anything with upper bits set is undefined.
  assign op_legal = ((opcode >> 3) == '0);
  assign hold     = stall && is_stallable(state_q);

  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clock),
    .rst       (reset),
    .wait_i    (is_mem_state(state_q) && !rdy),
    .timeout_o (tmo)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (rdy) state_d = S_DECODE; else if (tmo) state_d = S_ERR;
      S_DECODE: begin
        if (!op_legal) state_d = (ILLEGAL_TRAP != 0) ? S_ERR : S_FETCH;
        else case (op3)
          OP_RTYPE:      state_d = S_EXEC_R;
          OP_ADDI:       state_d = S_EXEC_I;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR: state_d = (op_legal && op3 == OP_SW) ? S_MEM_WR :
                            (op_legal && op3 == OP_LW) ? S_MEM_RD : S_FETCH;
      S_MEM_RD: if (rdy) state_d = S_WB_MEM; else if (tmo) state_d = S_ERR;
      S_MEM_WR: if (rdy) state_d = S_FETCH;  else if (tmo) state_d = S_ERR;
      S_WB_MEM, S_WB_ALU, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_HALT:   if (resume) state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_ERR;
    endcase
    if (hold) state_d = state_q;
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_ALU;
    reg_write = 1'b0;
    reg_dst   = 1'b0;
    wb_sel    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = ASB_REGB;
    alu_op    = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = ASB_FOUR;
        ir_write  = rdy;
        pc_write  = rdy;
      end
      S_DECODE:   alu_src_b = ASB_IMM_SH;
      S_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = ASB_IMM; end
      S_MEM_RD:   begin mem_req = 1'b1; iord = 1'b1; end
      S_MEM_WR:   begin mem_req = 1'b1; mem_we = 1'b1; iord = 1'b1; end
      S_WB_MEM:   begin reg_write = 1'b1; wb_sel = 1'b1; end
      S_EXEC_R:   begin alu_src_a = 1'b1; alu_op = ALU_FUNCT; end
      S_EXEC_I:   begin alu_src_a = 1'b1; alu_src_b = ASB_IMM; end
      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = op_legal && (op3 == OP_RTYPE);
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_write  = op_legal && (((op3 == OP_BEQ) && zero) || ((op3 == OP_BNE) && !zero));
      end
      S_JUMP:   begin pc_src = PC_JUMP; pc_write = 1'b1; end
      default: ;
    endcase
    // Stall freezes architectural updates but keeps the selects steady.
    if (hold) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state_o = state_q;
  assign busy    = !((state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERR));
  assign error   = (state_q == S_ERR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_mc_controller_hs.sv
// Directed table-driven bench for mc_controller_hs plus hand sequences for reset, trap and NOP cases.
module tb_mc_controller_hs;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = '0;
  logic       zero = 1'b0, mem_ready = 1'b1, stall = 1'b0, resume = 1'b0;

  logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst, wb_sel, alu_src_a, busy, error;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state_o;

  logic       b_mem_req, b_mem_we, b_iord, b_ir_write, b_pc_write, b_reg_write, b_reg_dst, b_wb_sel;
  logic       b_alu_src_a, b_busy, b_error;
  logic [1:0] b_pc_src, b_alu_src_b, b_alu_op;
  logic [3:0] b_state_o;

  always #5 clock = ~clock;

  mc_controller_hs #(.OPC_W(4), .MEM_HANDSHAKE(1), .TIMEOUT(3), .ILLEGAL_TRAP(1)) u_dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .stall(stall), .resume(resume), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state_o(state_o), .busy(busy), .error(error));

  mc_controller_hs #(.OPC_W(4), .MEM_HANDSHAKE(1), .TIMEOUT(15), .ILLEGAL_TRAP(0)) u_nop (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .stall(stall), .resume(resume), .mem_req(b_mem_req), .mem_we(b_mem_we), .iord(b_iord),
    .ir_write(b_ir_write), .pc_write(b_pc_write), .pc_src(b_pc_src), .reg_write(b_reg_write),
    .reg_dst(b_reg_dst), .wb_sel(b_wb_sel), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
    .alu_op(b_alu_op), .state_o(b_state_o), .busy(b_busy), .error(b_error));

  logic [20:0] obs;
  assign obs = {state_o, mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
                reg_dst, wb_sel, alu_src_a, alu_src_b, alu_op, busy, error};

  typedef struct {
    logic [3:0]  opc;
    logic        z, mr, st, rs;
    logic [20:0] exp;
  } vec_t;

  vec_t v[$];
  int   n_chk = 0, n_err = 0;

  function automatic logic [20:0] e(input logic [3:0] s, input logic mreq, mwe, io, irw, pcw,
                                    input logic [1:0] pcs, input logic rw, rd, wb, asa,
                                    input logic [1:0] asb, aop, input logic bsy, err);
    return {s, mreq, mwe, io, irw, pcw, pcs, rw, rd, wb, asa, asb, aop, bsy, err};
  endfunction

  task automatic add(input logic [3:0] o, input logic z, mr, st, rs, input logic [20:0] x);
    vec_t t;
    t.opc = o; t.z = z; t.mr = mr; t.st = st; t.rs = rs; t.exp = x;
    v.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [20:0] IDLE_E, FETCH_R, FETCH_W, DEC_E, MADDR_E, MRD_E, MWR_E, WBM_E, EXR_E, EXI_E;
  logic [20:0] WBA_I, WBA_R, WBA_RS, BR_T, BR_N, JMP_E, HALT_E, ERR_E;

  initial begin
    IDLE_E  = e(0, 0,0,0,0,0, 2'd0, 0,0,0,0, 2'd0,2'd0, 0,0);
    FETCH_R = e(1, 1,0,0,1,1, 2'd0, 0,0,0,0, 2'd1,2'd0, 1,0);
    FETCH_W = e(1, 1,0,0,0,0, 2'd0, 0,0,0,0, 2'd1,2'd0, 1,0);
    DEC_E   = e(2, 0,0,0,0,0, 2'd0, 0,0,0,0, 2'd3,2'd0, 1,0);
    MADDR_E = e(3, 0,0,0,0,0, 2'd0, 0,0,0,1, 2'd2,2'd0, 1,0);
    MRD_E   = e(4, 1,0,1,0,0, 2'd0, 0,0,0,0, 2'd0,2'd0, 1,0);
    MWR_E   = e(5, 1,1,1,0,0, 2'd0, 0,0,0,0, 2'd0,2'd0, 1,0);
    WBM_E   = e(6, 0,0,0,0,0, 2'd0, 1,0,1,0, 2'd0,2'd0, 1,0);
    EXR_E   = e(7, 0,0,0,0,0, 2'd0, 0,0,0,1, 2'd0,2'd2, 1,0);
    EXI_E   = e(8, 0,0,0,0,0, 2'd0, 0,0,0,1, 2'd2,2'd0, 1,0);
    WBA_I   = e(9, 0,0,0,0,0, 2'd0, 1,0,0,0, 2'd0,2'd0, 1,0);
    WBA_R   = e(9, 0,0,0,0,0, 2'd0, 1,1,0,0, 2'd0,2'd0, 1,0);
    WBA_RS  = e(9, 0,0,0,0,0, 2'd0, 0,1,0,0, 2'd0,2'd0, 1,0);
    BR_T    = e(10,0,0,0,0,1, 2'd1, 0,0,0,1, 2'd0,2'd1, 1,0);
    BR_N    = e(10,0,0,0,0,0, 2'd1, 0,0,0,1, 2'd0,2'd1, 1,0);
    JMP_E   = e(11,0,0,0,0,1, 2'd2, 0,0,0,0, 2'd0,2'd0, 1,0);
    HALT_E  = e(12,0,0,0,0,0, 2'd0, 0,0,0,0, 2'd0,2'd0, 0,0);
    ERR_E   = e(15,0,0,0,0,0, 2'd0, 0,0,0,0, 2'd0,2'd0, 0,1);

    //   opc z mr st rs  expected
    add(1, 0,1,0,0, IDLE_E);   // ADDI
    add(1, 0,1,0,0, FETCH_R);
    add(1, 0,1,0,0, DEC_E);
    add(1, 0,1,0,0, EXI_E);
    add(1, 0,1,0,0, WBA_I);
    add(2, 0,1,0,0, FETCH_R);  // LW, three wait cycles in MEM_RD
    add(2, 0,1,0,0, DEC_E);
    add(2, 0,1,0,0, MADDR_E);
    add(2, 0,0,0,0, MRD_E);
    add(2, 0,0,0,0, MRD_E);
    add(2, 0,0,0,0, MRD_E);
    add(2, 0,1,0,0, MRD_E);    // ready on the timeout cycle wins
    add(2, 0,1,0,0, WBM_E);
    add(4, 1,1,0,0, FETCH_R);  // BEQ taken
    add(4, 1,1,0,0, DEC_E);
    add(4, 1,1,0,0, BR_T);
    add(5, 1,1,0,0, FETCH_R);  // BNE not taken
    add(5, 1,1,0,0, DEC_E);
    add(5, 1,1,0,0, BR_N);
    add(0, 0,1,0,0, FETCH_R);  // RTYPE, stalled 2 cycles in EXEC_R
    add(0, 0,1,0,0, DEC_E);
    add(0, 0,1,1,0, EXR_E);
    add(0, 0,1,1,0, EXR_E);
    add(0, 0,1,0,0, EXR_E);
    add(0, 0,1,0,0, WBA_R);
    add(3, 0,1,0,0, FETCH_R);  // SW, stall ignored in MEM_WR
    add(3, 0,1,0,0, DEC_E);
    add(3, 0,1,0,0, MADDR_E);
    add(3, 0,0,1,0, MWR_E);
    add(3, 0,1,1,0, MWR_E);
    add(7, 0,1,0,0, FETCH_R);  // HALT / resume
    add(7, 0,1,0,0, DEC_E);
    add(7, 0,1,0,0, HALT_E);
    add(7, 0,1,0,1, HALT_E);
    add(6, 0,1,0,0, FETCH_R);  // J
    add(6, 0,1,0,0, DEC_E);
    add(6, 0,1,0,0, JMP_E);
    add(0, 0,1,1,0, FETCH_R);  // stall ignored in FETCH, honoured in DECODE and WB_ALU
    add(0, 0,1,1,0, DEC_E);
    add(0, 0,1,0,0, DEC_E);
    add(0, 0,1,0,0, EXR_E);
    add(0, 0,1,1,0, WBA_RS);
    add(0, 0,1,0,0, WBA_R);
    add(0, 0,0,0,0, FETCH_W);  // timeout: four waiting FETCH cycles then ERR
    add(0, 0,0,0,0, FETCH_W);
    add(0, 0,0,0,0, FETCH_W);
    add(0, 0,0,0,0, FETCH_W);
    add(0, 0,0,0,0, ERR_E);
    add(0, 0,1,0,1, ERR_E);
    add(0, 0,1,0,0, ERR_E);

    repeat (2) @(negedge clock);
    #1;
    chk("reset_state", {28'd0, state_o}, 32'd0);
    chk("reset_busy",  {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < v.size(); i++) begin
      opcode = v[i].opc; zero = v[i].z; mem_ready = v[i].mr; stall = v[i].st; resume = v[i].rs;
      #1;
      chk($sformatf("vec%0d", i), {11'd0, obs}, {11'd0, v[i].exp});
      @(negedge clock);
    end

    // Asynchronous reset mid-cycle from ERR, checked before the next rising edge.
    #1;
    chk("err_sticky", {28'd0, state_o}, 32'd15);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_state", {28'd0, state_o}, 32'd0);
    chk("async_rst_error", {31'd0, error}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    stall = 1'b0; resume = 1'b0; mem_ready = 1'b1;

    // Undefined opcode 9: trap instance goes to ERR, NOP instance returns to FETCH.
    opcode = 4'd9;
    #1;
    chk("ill_idle", {28'd0, state_o}, 32'd0);
    chk("nop_idle", {28'd0, b_state_o}, 32'd0);
    @(negedge clock); #1;
    chk("ill_fetch", {28'd0, state_o}, 32'd1);
    @(negedge clock); #1;
    chk("ill_decode", {28'd0, state_o}, 32'd2);
    chk("nop_decode", {28'd0, b_state_o}, 32'd2);
    @(negedge clock); #1;
    chk("ill_trap_state", {28'd0, state_o}, 32'd15);
    chk("ill_trap_error", {31'd0, error}, 32'd1);
    chk("nop_state", {28'd0, b_state_o}, 32'd1);
    chk("nop_error", {31'd0, b_error}, 32'd0);
    chk("nop_busy",  {31'd0, b_busy}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_controller_hs.md
Name: mc_controller_hs

Overview:
- Parametrised next-generation multicycle CPU control FSM. Decodes an encoded opcode and sequences fetch/decode/execute/memory/writeback.
- Adds features the current controller lacks:
  - variable-latency memory handshake with timeout,
  - pipeline-style stall,
  - branch-condition evaluation,
  - halt/resume,
  - illegal-opcode trap.
- Sits between the instruction register and the datapath. Drives all datapath mux selects and write enables.

Parameters:
- OPC_W, 4, width of encoded opcode input (>=3).
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready internally forced to 1.
- TIMEOUT, 15, max wait cycles with mem_req high and no mem_ready before trapping; 0 disables the timeout.
- ILLEGAL_TRAP, 1, 1 = undefined opcode goes to ERR; 0 = treated as NOP (return to FETCH).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  OPC_W  opcode from IR; stable after DECODE.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- stall  in  1  hold request.
- resume  in  1  leave HALT.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  write request qualifier.
- iord  out  1  address source: 0 = PC, 1 = ALU-out.
- ir_write  out  1  IR load enable.
- pc_write  out  1  PC load enable.
- pc_src  out  2  00 = ALU, 01 = ALU-out, 10 = jump target.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination select: 1 = rd, 0 = rt.
- wb_sel  out  1  writeback source: 0 = ALU-out, 1 = MDR.
- alu_src_a  out  1  0 = PC, 1 = regA.
- alu_src_b  out  2  00 = regB, 01 = const 4, 10 = imm, 11 = imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct.
- state_o  out  4  current state encoding.
- busy  out  1  high unless in IDLE, HALT or ERR.
- error  out  1  high in ERR.

Behaviour:
- Clocking and reset: one clock domain, `clock`; `reset` is asynchronous and active-high. Reset forces state IDLE.
- IDLE outputs: all outputs 0, state_o = IDLE. IDLE always goes to FETCH next cycle.
- Output structure: outputs are combinational from state, plus rdy = (MEM_HANDSHAKE ? mem_ready : 1) and zero. Any output not listed for a state is 0.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=rdy, pc_write=rdy. rdy -> DECODE, else stay.
- DECODE: alu_src_a=0, alu_src_b=11, add. Next state by opcode:
  - RTYPE -> EXEC_R
  - ADDI -> EXEC_I
  - LW or SW -> MEM_ADDR
  - BEQ or BNE -> BRANCH
  - J -> JUMP
  - HALT -> HALT
  - other -> ERR or FETCH, per ILLEGAL_TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add. LW -> MEM_RD; SW -> MEM_WR.
- MEM_RD: mem_req=1, iord=1. rdy -> WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, iord=1. rdy -> FETCH.
- WB_MEM: reg_write=1, wb_sel=1, reg_dst=0 -> FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10, add -> WB_ALU.
- WB_ALU: reg_write=1, wb_sel=0, reg_dst=(opcode==RTYPE) -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01. pc_write = (BEQ & zero) | (BNE & ~zero) -> FETCH.
- JUMP: pc_src=10, pc_write=1 -> FETCH.
- HALT: busy=0. resume -> FETCH.
- ERR: error=1, sticky until reset.
- Stall:
  - Applies in DECODE, MEM_ADDR, EXEC_R, EXEC_I, WB_ALU, WB_MEM, BRANCH, JUMP.
  - Effect: state held; pc_write, ir_write, reg_write forced 0; selects still driven.
  - Ignored in FETCH, MEM_RD, MEM_WR, because an outstanding request is never dropped.
- Timeout:
  - wait_cnt (width clog2(TIMEOUT+1)) increments each cycle in a memory state with rdy=0, and clears on any state change.
  - When wait_cnt == TIMEOUT and rdy=0 (TIMEOUT != 0): go to ERR next cycle; mem_req drops there.
  - rdy arriving in that same cycle wins: normal transition.
- Latency with rdy=1: R/ADDI 4 cycles, LW 5, SW 4, branch/jump 3.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode constants (RTYPE=0, ADDI=1, LW=2, SW=3, BEQ=4, BNE=5, J=6, HALT=7),
  - state encodings (IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WR=5, WB_MEM=6, EXEC_R=7, EXEC_I=8, WB_ALU=9, BRANCH=10, JUMP=11, HALT=12, ERR=15),
  - alu_src_b / alu_op / pc_src codes.
- One sub-module, mc_wait_timer (wait_cnt plus timeout flag).

Test Plan:
- Reset, then ADDI (opcode=1), mem_ready=1 -> states 0,1,2,8,9,1. reg_write=1 only in WB_ALU, reg_dst=0.
- LW with mem_ready low 3 cycles in MEM_RD -> mem_req held 4 cycles, iord=1. WB_MEM follows with wb_sel=1.
- BEQ with zero=1 -> pc_write=1, pc_src=01. BNE with zero=1 -> pc_write=0.
- TIMEOUT=3, mem_ready=0 in FETCH -> ERR after 4 FETCH cycles; error=1 until reset. Asserting reset mid-ERR -> IDLE immediately, asynchronously.
- stall=1 for 2 cycles in EXEC_R -> state_o=7 for 3 cycles, no write enables. stall asserted in MEM_WR -> ignored, mem_req continuous.
- Opcode 9 with ILLEGAL_TRAP=1 -> ERR. With ILLEGAL_TRAP=0 -> FETCH. HALT then resume pulse -> FETCH; busy=0 while halted.
